// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned) with flush, div0 results and pipeline stall.
// Optional DIV_EARLY_EXIT_EN: skip the dividend's leading zeros to shorten the iteration count.
//
// state | meaning
// IDLE  | waiting for en; s/r hold the last result
// CALC  | one restoring step per cycle, counter runs down to 0
// FIX   | apply signs / div0 override, load s and r
// DONE  | res_ready pulse, back to IDLE

module iter_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_sign,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    output logic             res_ready,
    output logic             busy,
    output logic             stall_all
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             res_ready_q, res_ready_d;

    logic             a_neg, b_neg, start, b_zero;
    logic [WIDTH-1:0] abs_a, abs_b, quo_init;
    logic [CNT_W-1:0] iters;
    logic [WIDTH:0]   rem_sh, diff;

    assign a_neg  = div_sign & src_a[WIDTH-1];
    assign b_neg  = div_sign & src_b[WIDTH-1];
    assign abs_a  = a_neg ? -src_a : src_a;
    assign abs_b  = b_neg ? -src_b : src_b;
    assign b_zero = (src_b == '0);
    assign start  = (state_q == IDLE) & en & ~flush;

`ifdef DIV_EARLY_EXIT_EN
    logic [CNT_W-1:0] lz;

    always_comb begin
        lz = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (abs_a[i]) begin
                lz = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

    // Pre-shifting lets the quotient register still shift out exactly WIDTH-lz dividend bits.
    assign iters    = CNT_W'(WIDTH) - lz;
    assign quo_init = abs_a << lz;
`else
    assign iters    = CNT_W'(WIDTH);
    assign quo_init = abs_a;
`endif

    // Top bit of the (WIDTH+1)-bit difference is the borrow of the trial subtract.
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    always_comb begin
        state_d     = state_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        div0_d      = div0_q;
        a_raw_d     = a_raw_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        s_d         = s_q;
        r_d         = r_q;
        res_ready_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    div0_d  = b_zero;
                    a_raw_d = src_a;
                    dvs_d   = abs_b;
                    rem_d   = '0;
                    quo_d   = quo_init;
                    cnt_d   = iters;
                    state_d = (b_zero || iters == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                rem_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (div0_q) begin
                    s_d = '1;
                    r_d = a_raw_q;
                end else begin
                    s_d = qneg_q ? -quo_q : quo_q;
                    r_d = rneg_q ? -rem_q : rem_q;
                end
                res_ready_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An abort leaves s/r untouched; in DONE the pulse is already out.
        if (flush && state_q != IDLE) begin
            state_d     = IDLE;
            s_d         = s_q;
            r_d         = r_q;
            res_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            div0_q      <= 1'b0;
            a_raw_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            s_q         <= '0;
            r_q         <= '0;
            res_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            div0_q      <= div0_d;
            a_raw_q     <= a_raw_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            r_q         <= r_d;
            res_ready_q <= res_ready_d;
        end
    end

    assign s         = s_q;
    assign r         = r_q;
    assign res_ready = res_ready_q;
    assign busy      = (state_q != IDLE);
    assign stall_all = start | (state_q == CALC) | (state_q == FIX);

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Parametrised multi-cycle radix-2 integer divider for the EXU; successor to the fixed 32-bit IP-core divider.
- Takes over DIV/DIVU (signed/unsigned per operation) with no vendor IP, at any WIDTH.
- Adds flush/abort, defined divide-by-zero results and a busy/handshake interface.
- Drives stall_all to the pipeline exactly as the current divider does.

Parameters:
- WIDTH, 32, operand/quotient/remainder width in bits (≥4).
- CNT_W, $clog2(WIDTH+1), iteration-counter width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  start request; sampled only in IDLE.
- div_sign  in  1  1 = signed (two's complement), 0 = unsigned; captured with en.
- src_a  in  WIDTH  dividend; captured with en.
- src_b  in  WIDTH  divisor; captured with en.
- flush  in  1  synchronous abort of the in-flight operation.
- s  out  WIDTH  quotient (registered).
- r  out  WIDTH  remainder (registered).
- res_ready  out  1  one-cycle pulse: s/r valid.
- busy  out  1  operation in flight (state ≠ IDLE).
- stall_all  out  1  pipeline stall request.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, s=0, r=0, res_ready=0, busy=0, internal regs 0. Reset mid-operation discards the operation.
- States: IDLE, CALC, FIX, DONE.
- Start acceptance: cycle T with state=IDLE, en=1, flush=0.
  - Capture div_sign, sign bits, |src_a|, |src_b| (magnitudes only if div_sign=1).
  - Capture a div0 flag (src_b==0).
  - Next state: CALC, or FIX if div0 or iteration count is 0.
- CALC: one restoring step per cycle.
  - Shift {rem,quo} left 1; trial-subtract divisor from rem (WIDTH+1-bit subtract).
  - On no borrow, keep the difference and set the quotient LSB.
  - Counter counts down from the iteration count; at 0, go to FIX.
  - Full mode: WIDTH cycles, T+1..T+WIDTH.
- FIX:
  - Quotient is negated iff div_sign and the operand signs differ.
  - Remainder is negated iff div_sign and the dividend is negative.
  - div0 overrides: s=all ones, r=src_a as given (unsigned and signed alike).
  - Load s/r; next state DONE.
- DONE: res_ready=1 for exactly this cycle; next state IDLE.
- Latency: res_ready at T+WIDTH+2 in normal operation; at T+2 for div0.
- s/r hold their last value until the next result is loaded. Starting a new operation does not clear them.
- Overflow case (signed MIN / -1): falls out naturally as s=MIN, r=0, with no special path.
- stall_all = (state==IDLE & en & ~flush) | state==CALC | state==FIX. It is low in DONE, the cycle in which the consumer takes the result.
- busy = state≠IDLE.
- en while busy: ignored; no queuing.
- flush: any state except IDLE goes to IDLE on the next edge.
  - No res_ready is issued; s/r are not updated.
  - flush in DONE is too late: res_ready is already high that cycle.
- flush and en in the same IDLE cycle: flush wins; the start is dropped and stall_all=0.
- New start is legal in the cycle after DONE (back-to-back ops; minimum spacing WIDTH+3 cycles).

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined:
  - At start, a leading-zero count lz of |src_a| sets the iteration count to WIDTH-lz.
  - The dividend is pre-shifted left by lz.
  - res_ready arrives at T+(WIDTH-lz)+2.
  - Dividend 0 gives 0 iterations: FIX at T+1, res_ready at T+2.
  - Results are bit-identical to the undefined case.
- Undefined: fixed WIDTH iterations; no leading-zero logic is synthesised.

Test Plan (WIDTH=32):
- Unsigned 100/7, en at T -> res_ready only at T+34; s=14, r=2; stall_all high T..T+33, low at T+34.
- Signed -7/2 (0xFFFFFFF9/0x2) -> s=0xFFFFFFFD, r=0xFFFFFFFF. Unsigned same bits -> s=0x7FFFFFFC, r=1.
- Divide-by-zero 5/0, both modes -> res_ready at T+2; s=0xFFFFFFFF, r=5. Signed 0x80000000/0xFFFFFFFF -> s=0x80000000, r=0 at T+34.
- Abort and back-to-back:
  - Start 1000/3, flush at T+10 -> busy low at T+11, no res_ready; prior s/r unchanged.
  - Start 9/4 at T+11 -> s=2, r=1 at T+45.
  - en held high during busy causes no extra op.
- Reset: rst low at T+5 mid-op -> all outputs 0 immediately; after release, 6/3 yields s=2, r=0.
- DIV_EARLY_EXIT_EN: unsigned 3/1 -> res_ready at T+4, s=3, r=0; 0/9 -> res_ready at T+2, s=0, r=0; 0xFFFFFFFF/1 -> T+34.
